pipelined_add_sub: RTL

Parametrised, pipelined two's-complement adder/subtractor and the successor to the team's 4-bit ripple-carry adder. The operand width is split into STAGES equal chunks. Each pipeline stage ripple-adds one chunk and registers the carry into the next stage. Operands stream in and results stream out through valid/ready handshakes, so the block can sit in a datapath that applies backpressure.

---
 rtl/pipelined_add_sub.sv | 111 +++++++++++
 1 files changed

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: WIDTH bits split into STAGES chunks,
// one chunk ripple-added per stage with the carry registered between stages.
module pipelined_add_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int CW = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_add_sub: WIDTH (%0d) must be >= 2 and a multiple of STAGES (%0d)",
           WIDTH, STAGES);
  end

  // Same-sign operands giving a different-sign result; equivalent to
  // carry-into-MSB XOR carry-out-of-MSB.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM  = WIDTH - k * CW;  // operand bits not yet consumed
    localparam int DONE = (k + 1) * CW;    // result bits known after this stage

    logic [REM-1:0]  a_rem;
    logic [REM-1:0]  b_rem;
    logic            c_in;
    logic            vld_in;
    logic [CW:0]     chunk;
    logic [DONE-1:0] sum_d;
    logic [DONE-1:0] sum_q;
    logic            carry_q;
    logic            vld_q;

    // Stage input: raw operands for stage 0, previous stage registers otherwise
    if (k == 0) begin : g_src0
      assign a_rem  = in_a;
      assign b_rem  = in_sub ? ~in_b : in_b;
      assign c_in   = in_sub | in_cin;
      assign vld_in = in_valid;
      assign sum_d  = chunk[CW-1:0];
    end else begin : g_srcn
      assign a_rem  = g_stage[k-1].g_mid.a_q;
      assign b_rem  = g_stage[k-1].g_mid.b_q;
      assign c_in   = g_stage[k-1].carry_q;
      assign vld_in = g_stage[k-1].vld_q;
      assign sum_d  = {chunk[CW-1:0], g_stage[k-1].sum_q};
    end

    assign chunk = {1'b0, a_rem[CW-1:0]} + {1'b0, b_rem[CW-1:0]} + {{CW{1'b0}}, c_in};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   vld_q <= 1'b0;
      else if (adv) vld_q <= vld_in;
    end

    // Stage register: partial sum, carry and the operand chunks still to be added
    if (k < STAGES - 1) begin : g_mid
      logic [REM-CW-1:0] a_q;
      logic [REM-CW-1:0] b_q;

      always_ff @(posedge clk) begin
        if (adv) begin
          sum_q   <= sum_d;
          carry_q <= chunk[CW];
          a_q     <= a_rem[REM-1:CW];
          b_q     <= b_rem[REM-1:CW];
        end
      end
    end else begin : g_last
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q   <= '0;
          carry_q <= 1'b0;
          ovf_q   <= 1'b0;
        end else if (adv) begin
          sum_q   <= sum_d;
          carry_q <= chunk[CW];
          ovf_q   <= signed_ovf(a_rem[REM-1], b_rem[REM-1], chunk[CW-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign out_sum   = g_stage[STAGES-1].sum_q;
  assign out_cout  = g_stage[STAGES-1].carry_q;
  assign out_ovf   = g_stage[STAGES-1].g_last.ovf_q;

endmodule
